// File: rtl/wb_pkg.sv
// Shared types for the writeback commit unit: queued entry layout, commit FSM states
// and the rule that picks which write of an entry is issued first.
package wb_pkg;

   // Entry fields are sized for the widest build; DATA_W/ADDR_W must not exceed these.
   localparam int WB_DATA_W = 32;
   localparam int WB_ADDR_W = 4;

   typedef struct packed {
      logic [WB_DATA_W-1:0] data1;
      logic [WB_ADDR_W-1:0] dst1;
      logic                 we1;
      logic [WB_DATA_W-1:0] data2;
      logic [WB_ADDR_W-1:0] dst2;
      logic                 we2;
      logic [WB_DATA_W-1:0] cpsr;
      logic                 cpsr_we;
   } wb_entry_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      W1   = 2'd1,
      W2   = 2'd2
   } wb_state_t;

   // A zero-write entry still spends one cycle in W1 so it can retire and update CPSR.
   function automatic wb_state_t first_state(input wb_entry_t e);
      return (e.we2 && !e.we1) ? W2 : W1;
   endfunction

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO of writeback entries with full/empty/count.
// With WB_HAZARD_EN defined it also exposes the entry array and a valid mask.
module wb_fifo
   import wb_pkg::*;
#(
   parameter int DEPTH = 4
)
(
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         push,
   input  wb_entry_t                    push_entry,
   input  logic                         pop,
   output wb_entry_t                    head,
   output logic                         full,
   output logic                         empty,
   output logic [$clog2(DEPTH+1)-1:0]   count
`ifdef WB_HAZARD_EN
   ,
   output wb_entry_t                    entries [DEPTH],
   output logic [DEPTH-1:0]             valid_mask
`endif
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH+1);

   wb_entry_t        mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_push, do_pop;

   assign full  = (count_q == CNT_W'(DEPTH));
   assign empty = (count_q == '0);
   assign count = count_q;
   assign head  = mem_q[rd_ptr_q];

   always_comb begin
      do_push  = push && !full;
      do_pop   = pop && !empty;
      wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
      rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
      count_d  = count_q;
      if (do_push && !do_pop) begin
         count_d = count_q + CNT_W'(1);
      end else if (do_pop && !do_push) begin
         count_d = count_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= push_entry;
      end
   end

`ifdef WB_HAZARD_EN
   // Slot gi is live when its distance from the read pointer is below the count.
   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_valid
      logic [PTR_W-1:0] offset;
      assign offset         = PTR_W'(gi) - rd_ptr_q;
      assign valid_mask[gi] = (CNT_W'(offset) < count_q);
      assign entries[gi]    = mem_q[gi];
   end
`endif

endmodule

// File: rtl/wb_commit_unit.sv
// Buffered writeback stage: queues ALU results and commits them one register write per
// cycle in program order. Optional hazard query port enabled by defining WB_HAZARD_EN.
module wb_commit_unit
   import wb_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 4,
   parameter int DEPTH  = 4
)
(
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [DATA_W-1:0]            in_data1,
   input  logic [ADDR_W-1:0]            in_dst1,
   input  logic                         in_we1,
   input  logic [DATA_W-1:0]            in_data2,
   input  logic [ADDR_W-1:0]            in_dst2,
   input  logic                         in_we2,
   input  logic [DATA_W-1:0]            in_cpsr,
   input  logic                         in_cpsr_we,
   output logic                         rf_we,
   output logic [ADDR_W-1:0]            rf_addr,
   output logic [DATA_W-1:0]            rf_data,
   input  logic                         rf_stall,
   output logic                         cpsr_we,
   output logic [DATA_W-1:0]            cpsr_out,
   output logic                         retire,
   output logic [$clog2(DEPTH+1)-1:0]   occupancy
`ifdef WB_HAZARD_EN
   ,
   input  logic [ADDR_W-1:0]            hz_addr,
   output logic                         hz_hit
`endif
);

   wb_entry_t            in_entry, head_entry;
   wb_entry_t            work_q, work_d;
   wb_state_t            state_q, state_d;
   logic [WB_DATA_W-1:0] cpsr_q, cpsr_d;
   logic                 fifo_full, fifo_empty, push;
   logic                 entry_done, load_next;

   always_comb begin
      in_entry         = '0;
      in_entry.data1   = WB_DATA_W'(in_data1);
      in_entry.dst1    = WB_ADDR_W'(in_dst1);
      in_entry.we1     = in_we1;
      in_entry.data2   = WB_DATA_W'(in_data2);
      in_entry.dst2    = WB_ADDR_W'(in_dst2);
      in_entry.we2     = in_we2;
      in_entry.cpsr    = WB_DATA_W'(in_cpsr);
      in_entry.cpsr_we = in_cpsr_we;
   end

   assign in_ready = !fifo_full && !reset;
   assign push     = in_valid && in_ready;

`ifdef WB_HAZARD_EN
   wb_entry_t        fifo_entries [DEPTH];
   logic [DEPTH-1:0] fifo_valid;
`endif

   wb_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk        (clk),
      .reset      (reset),
      .push       (push),
      .push_entry (in_entry),
      .pop        (load_next),
      .head       (head_entry),
      .full       (fifo_full),
      .empty      (fifo_empty),
      .count      (occupancy)
`ifdef WB_HAZARD_EN
      ,
      .entries    (fifo_entries),
      .valid_mask (fifo_valid)
`endif
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         work_q  <= '0;
         cpsr_q  <= '0;
      end else begin
         state_q <= state_d;
         work_q  <= work_d;
         cpsr_q  <= cpsr_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      work_d     = work_q;
      cpsr_d     = cpsr_q;
      entry_done = 1'b0;
      load_next  = 1'b0;
      case (state_q)
         IDLE: load_next = !fifo_empty;
         W1: begin
            if (!(work_q.we1 && rf_stall)) begin
               if (work_q.we2) begin
                  state_d = W2;
               end else begin
                  entry_done = 1'b1;
               end
            end
         end
         W2: entry_done = !rf_stall;
         default: state_d = IDLE;
      endcase
      // Completing an entry immediately loads the next head so there is no bubble.
      if (entry_done) begin
         if (work_q.cpsr_we) begin
            cpsr_d = work_q.cpsr;
         end
         if (fifo_empty) begin
            state_d = IDLE;
         end else begin
            load_next = 1'b1;
         end
      end
      if (load_next) begin
         state_d = first_state(head_entry);
         work_d  = head_entry;
      end
   end

   always_comb begin
      rf_we   = 1'b0;
      rf_addr = '0;
      rf_data = '0;
      retire  = 1'b0;
      cpsr_we = 1'b0;
      if (!reset) begin
         case (state_q)
            W1: begin
               if (work_q.we1) begin
                  rf_we   = 1'b1;
                  rf_addr = ADDR_W'(work_q.dst1);
                  rf_data = DATA_W'(work_q.data1);
               end
            end
            W2: begin
               rf_we   = 1'b1;
               rf_addr = ADDR_W'(work_q.dst2);
               rf_data = DATA_W'(work_q.data2);
            end
            default: ;
         endcase
         retire  = entry_done;
         cpsr_we = entry_done && work_q.cpsr_we;
      end
   end

   assign cpsr_out = DATA_W'(cpsr_q);

`ifdef WB_HAZARD_EN
   logic [WB_ADDR_W-1:0] hz_key;
   logic [DEPTH-1:0]     entry_hit;
   logic                 work_hit;

   assign hz_key = WB_ADDR_W'(hz_addr);

   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_hazard
      assign entry_hit[gi] = fifo_valid[gi] &&
                             ((fifo_entries[gi].we1 && (fifo_entries[gi].dst1 == hz_key)) ||
                              (fifo_entries[gi].we2 && (fifo_entries[gi].dst2 == hz_key)));
   end

   // In W2 the first write has already landed; only the second is still pending.
   always_comb begin
      work_hit = 1'b0;
      if (state_q == W1) begin
         work_hit = (work_q.we1 && (work_q.dst1 == hz_key)) ||
                    (work_q.we2 && (work_q.dst2 == hz_key));
      end else if (state_q == W2) begin
         work_hit = (work_q.dst2 == hz_key);
      end
   end

   assign hz_hit = !reset && ((|entry_hit) || work_hit);
`endif

endmodule
